// File: rtl/time_uart_tx_pkg.sv
// Shared definitions for the timestamp UART transmitter: ASCII codes, frame
// geometry, FSM states, the latched-digit payload and the char-selection mux.
package time_uart_tx_pkg;

    localparam int unsigned FRAME_LEN  = 21;
    localparam int unsigned CHAR_IDX_W = 5;
    localparam int unsigned BIT_IDX_W  = 3;
    localparam int unsigned SHIFT_W    = 10;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] year_thou;
        logic [3:0] year_hund;
        logic [3:0] year_ten;
        logic [3:0] year_unit;
        logic [1:0] month_ten;
        logic [3:0] month_unit;
        logic [1:0] day_ten;
        logic [3:0] day_unit;
        logic [1:0] hour_ten;
        logic [3:0] hour_unit;
        logic [3:0] min_ten;
        logic [3:0] min_unit;
        logic [3:0] sec_ten;
        logic [3:0] sec_unit;
    } stamp_t;

    // Non-decimal digit values are flagged on the line as '?'.
    function automatic logic [7:0] digit_char(input logic [3:0] v);
        return (v > 4'd9) ? ASCII_QMARK : ASCII_ZERO + {4'd0, v};
    endfunction

    function automatic logic [7:0] frame_char(input logic [CHAR_IDX_W-1:0] idx,
                                              input stamp_t s);
        logic [7:0] ch;
        ch = ASCII_LF;
        case (idx)
            5'd0:    ch = digit_char(s.year_thou);
            5'd1:    ch = digit_char(s.year_hund);
            5'd2:    ch = digit_char(s.year_ten);
            5'd3:    ch = digit_char(s.year_unit);
            5'd4:    ch = ASCII_DASH;
            5'd5:    ch = digit_char({2'd0, s.month_ten});
            5'd6:    ch = digit_char(s.month_unit);
            5'd7:    ch = ASCII_DASH;
            5'd8:    ch = digit_char({2'd0, s.day_ten});
            5'd9:    ch = digit_char(s.day_unit);
            5'd10:   ch = ASCII_SPACE;
            5'd11:   ch = digit_char({2'd0, s.hour_ten});
            5'd12:   ch = digit_char(s.hour_unit);
            5'd13:   ch = ASCII_COLON;
            5'd14:   ch = digit_char(s.min_ten);
            5'd15:   ch = digit_char(s.min_unit);
            5'd16:   ch = ASCII_COLON;
            5'd17:   ch = digit_char(s.sec_ten);
            5'd18:   ch = digit_char(s.sec_unit);
            5'd19:   ch = ASCII_CR;
            default: ch = ASCII_LF;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/time_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while running and flags the
// last cycle of each bit; restart realigns the count to a new frame.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Reload at every bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || !run || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_end_c = run && !restart && (cnt_q == CNT_LAST);

endmodule

// File: rtl/time_uart_tx.sv
// Snapshots a BCD timestamp on start and sends "YYYY-MM-DD hh:mm:ss\r\n"
// as back-to-back 8N1 characters.
module time_uart_tx
    import time_uart_tx_pkg::*;
#(
    parameter int unsigned F_IN = 50_000_000,
    parameter int unsigned BAUD = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] year_thou,
    input  logic [3:0] year_hund,
    input  logic [3:0] year_ten,
    input  logic [3:0] year_unit,
    input  logic [1:0] month_ten,
    input  logic [3:0] month_unit,
    input  logic [1:0] day_ten,
    input  logic [3:0] day_unit,
    input  logic [1:0] hour_ten,
    input  logic [3:0] hour_unit,
    input  logic [3:0] min_ten,
    input  logic [3:0] min_unit,
    input  logic [3:0] sec_ten,
    input  logic [3:0] sec_unit,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CLKS_PER_BIT = F_IN / BAUD;
    localparam logic [CHAR_IDX_W-1:0] LAST_CHAR = CHAR_IDX_W'(FRAME_LEN - 1);
    localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(7);

    state_e                 state_q, state_d;
    logic [CHAR_IDX_W-1:0]  char_idx_q, char_idx_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [SHIFT_W-1:0]     shreg_q, shreg_d;
    stamp_t                 stamp_q, stamp_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    stamp_t                 live_c;
    stamp_t                 sel_stamp_c;
    logic [CHAR_IDX_W-1:0]  sel_idx_c;
    logic [7:0]             next_char_c;
    logic                   accept_c;
    logic                   bit_end_c;

    assign live_c = {year_thou, year_hund, year_ten, year_unit,
                     month_ten, month_unit, day_ten, day_unit,
                     hour_ten, hour_unit, min_ten, min_unit,
                     sec_ten, sec_unit};

    assign accept_c = start && (state_q == ST_IDLE) && !busy_q && !done_q;

    // Char 0 comes from the live inputs on the accepting edge; later chars from the snapshot.
    always_comb begin
        sel_idx_c   = '0;
        sel_stamp_c = live_c;
        if (state_q != ST_IDLE) begin
            sel_idx_c   = char_idx_q + CHAR_IDX_W'(1);
            sel_stamp_c = stamp_q;
        end
    end

    assign next_char_c = frame_char(sel_idx_c, sel_stamp_c);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (accept_c),
        .run       (busy_q),
        .bit_end_c (bit_end_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            char_idx_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '1;
            stamp_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            stamp_q    <= stamp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Shift register holds {stop, data[7:0], start}; bit 0 is the line, ones shift in.
    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        stamp_d    = stamp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d    = ST_START;
                    busy_d     = 1'b1;
                    char_idx_d = '0;
                    bit_idx_d  = '0;
                    stamp_d    = live_c;
                    shreg_d    = {1'b1, next_char_c, 1'b0};
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    shreg_d = {1'b1, shreg_q[SHIFT_W-1:1]};
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    shreg_d = {1'b1, shreg_q[SHIFT_W-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (char_idx_q == LAST_CHAR) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        shreg_d = '1;
                    end else begin
                        state_d    = ST_START;
                        char_idx_d = char_idx_q + CHAR_IDX_W'(1);
                        shreg_d    = {1'b1, next_char_c, 1'b0};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx   = shreg_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_time_uart_tx.sv
// Directed/randomized bench for time_uart_tx: captures the line each cycle and
// checks it against a frame model built from the timestamp text format.
module tb_time_uart_tx;

    localparam int unsigned CPB       = 16;
    localparam int          NCHARS    = 21;
    localparam int          CHAR_CYC  = 10 * CPB;
    localparam int          FRAME_CYC = NCHARS * CHAR_CYC;
    localparam int          NSAMP     = FRAME_CYC + 2;

    localparam int M_PULSE    = 0;
    localparam int M_SCRAMBLE = 1;
    localparam int M_MIDPULSE = 2;
    localparam int M_HOLD     = 3;
    localparam int M_HOLDLAST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dig [14];
    logic       tx, busy, done;

    logic       tx_s   [NSAMP];
    logic       busy_s [NSAMP];
    logic       done_s [NSAMP];
    logic [7:0] exp_str [NCHARS];
    logic [7:0] dec     [NCHARS];

    logic [7:0] basic_ref [NCHARS] = '{8'h32, 8'h30, 8'h32, 8'h35, 8'h2D, 8'h30, 8'h33,
                                       8'h2D, 8'h30, 8'h37, 8'h20, 8'h31, 8'h34, 8'h3A,
                                       8'h30, 8'h39, 8'h3A, 8'h35, 8'h38, 8'h0D, 8'h0A};

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    time_uart_tx #(
        .F_IN (16),
        .BAUD (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .year_thou  (dig[0]),
        .year_hund  (dig[1]),
        .year_ten   (dig[2]),
        .year_unit  (dig[3]),
        .month_ten  (dig[4][1:0]),
        .month_unit (dig[5]),
        .day_ten    (dig[6][1:0]),
        .day_unit   (dig[7]),
        .hour_ten   (dig[8][1:0]),
        .hour_unit  (dig[9]),
        .min_ten    (dig[10]),
        .min_unit   (dig[11]),
        .sec_ten    (dig[12]),
        .sec_unit   (dig[13]),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_digit(input int v);
        return (v > 9) ? 8'h3F : 8'(48 + v);
    endfunction

    task automatic set_stamp(input int y, input int mo, input int d,
                             input int h, input int mi, input int s);
        dig[0]  = 4'(y / 1000);
        dig[1]  = 4'((y / 100) % 10);
        dig[2]  = 4'((y / 10) % 10);
        dig[3]  = 4'(y % 10);
        dig[4]  = 4'(mo / 10);
        dig[5]  = 4'(mo % 10);
        dig[6]  = 4'(d / 10);
        dig[7]  = 4'(d % 10);
        dig[8]  = 4'(h / 10);
        dig[9]  = 4'(h % 10);
        dig[10] = 4'(mi / 10);
        dig[11] = 4'(mi % 10);
        dig[12] = 4'(s / 10);
        dig[13] = 4'(s % 10);
    endtask

    task automatic rand_stamp();
        for (int i = 0; i < 14; i++) begin
            if (i == 4 || i == 6 || i == 8) dig[i] = 4'($urandom_range(3, 0));
            else                            dig[i] = 4'($urandom_range(15, 0));
        end
    endtask

    // Text model: "YYYY-MM-DD hh:mm:ss" + CR LF from the current digit values.
    task automatic build_exp();
        int dpos [14] = '{0, 1, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 17, 18};
        exp_str[4]  = 8'h2D;
        exp_str[7]  = 8'h2D;
        exp_str[10] = 8'h20;
        exp_str[13] = 8'h3A;
        exp_str[16] = 8'h3A;
        exp_str[19] = 8'h0D;
        exp_str[20] = 8'h0A;
        for (int i = 0; i < 14; i++) exp_str[dpos[i]] = ref_digit(int'(dig[i]));
    endtask

    // Expected line level k cycles after the first start-bit cycle.
    function automatic logic exp_bit(input int k);
        int         c;
        int         p;
        logic [7:0] b;
        c = k / CHAR_CYC;
        p = (k % CHAR_CYC) / CPB;
        b = exp_str[c];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    // Called with start already raised at a negedge; sample 0 follows the accepting edge.
    task automatic capture(input int mode);
        for (int k = 0; k < NSAMP; k++) begin
            @(negedge clk);
            tx_s[k]   = tx;
            busy_s[k] = busy;
            done_s[k] = done;
            case (mode)
                M_HOLD:     ;
                M_HOLDLAST: if (k == FRAME_CYC) start = 1'b0;
                M_MIDPULSE: start = (k == 1000 || k == FRAME_CYC - 1 || k == FRAME_CYC);
                default:    if (k == 0) start = 1'b0;
            endcase
            if (mode == M_SCRAMBLE) begin
                for (int i = 0; i < 14; i++) dig[i] = 4'd9;
            end
        end
    endtask

    task automatic verify(input string tag);
        int bad_wave  = 0;
        int good_bits = 0;
        int bad_busy  = 0;
        int early     = 0;
        chk({tag, "_tx_latency"},   32'(tx_s[0]),   32'(0));
        chk({tag, "_busy_latency"}, 32'(busy_s[0]), 32'(1));
        for (int c = 0; c < NCHARS; c++) begin
            logic [7:0] b;
            for (int i = 0; i < 8; i++) b[i] = tx_s[c * CHAR_CYC + CPB * (1 + i) + CPB / 2];
            dec[c] = b;
            chk($sformatf("%s_char%0d", tag, c), 32'(b), 32'(exp_str[c]));
        end
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (tx_s[k] !== exp_bit(k)) bad_wave++;
            if (busy_s[k] !== 1'b1)     bad_busy++;
            if (done_s[k] !== 1'b0)     early++;
        end
        for (int n = 0; n < NCHARS * 10; n++) begin
            int same = 0;
            for (int j = 0; j < CPB; j++) if (tx_s[n * CPB + j] === exp_bit(n * CPB)) same++;
            if (same == CPB) good_bits++;
        end
        chk({tag, "_wave_errs"},   32'(bad_wave),  32'(0));
        chk({tag, "_bit_periods"}, 32'(good_bits), 32'(NCHARS * 10));
        chk({tag, "_busy_drop"},   32'(bad_busy),  32'(0));
        chk({tag, "_early_done"},  32'(early),     32'(0));
        chk({tag, "_done_end"},    32'(done_s[FRAME_CYC]),     32'(1));
        chk({tag, "_busy_end"},    32'(busy_s[FRAME_CYC]),     32'(0));
        chk({tag, "_tx_end"},      32'(tx_s[FRAME_CYC]),       32'(1));
        chk({tag, "_done_once"},   32'(done_s[FRAME_CYC + 1]), 32'(0));
        chk({tag, "_idle_tx"},     32'(tx_s[FRAME_CYC + 1]),   32'(1));
    endtask

    task automatic pulse_frame(input string tag, input int mode);
        @(negedge clk);
        build_exp();
        start = 1'b1;
        capture(mode);
        verify(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 14; i++) dig[i] = 4'd0;
        #2 rst_n = 1'b0;

        // Reset state, with start asserted to show it is ignored while held in reset.
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("rst_tx",   32'(tx),   32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));

        // Basic frame accepted on the first edge after release.
        set_stamp(2025, 3, 7, 14, 9, 58);
        for (int c = 0; c < NCHARS; c++) exp_str[c] = basic_ref[c];
        rst_n = 1'b1;
        capture(M_PULSE);
        verify("basic");

        set_stamp(2025, 3, 7, 14, 9, 58);
        dig[13] = 4'hC;
        pulse_frame("invalid", M_PULSE);
        chk("invalid_char18", 32'(dec[18]), 32'(8'h3F));
        chk("invalid_char17", 32'(dec[17]), 32'(8'h35));

        set_stamp(9999, 12, 31, 23, 59, 59);
        pulse_frame("boundary", M_PULSE);

        rand_stamp();
        pulse_frame("scramble", M_SCRAMBLE);

        rand_stamp();
        pulse_frame("midpulse", M_MIDPULSE);
        @(negedge clk);
        chk("midpulse_no_extra", 32'(busy), 32'(0));

        // Start held high: frames follow after one done cycle and one idle edge.
        rand_stamp();
        pulse_frame("hold1", M_HOLD);
        capture(M_HOLDLAST);
        verify("hold2");
        @(negedge clk);
        chk("hold_stops", 32'(busy), 32'(0));

        // Reset during char 5 data bit 3 (month tens = 0, so the line is low there).
        set_stamp(2025, 3, 7, 14, 9, 58);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 5 * CHAR_CYC + 4 * CPB + CPB / 2; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        chk("prereset_tx",   32'(tx),   32'(0));
        chk("prereset_busy", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx",   32'(tx),   32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_stamp(1987, 11, 24, 6, 30, 5);
        pulse_frame("after_reset", M_PULSE);

        for (int r = 0; r < 2; r++) begin
            rand_stamp();
            pulse_frame($sformatf("rand%0d", r), M_PULSE);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/time_uart_tx.md
TIME_UART_TX -- requirements
Module: time_uart_tx

Interface
REQ-001 SHALL have parameter F_IN, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning serial bit rate; CLKS_PER_BIT = F_IN/BAUD (integer division, at least 2).
REQ-003 SHALL have port clk, input, 1, system clock. One clock only.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, snapshot-and-send request.
REQ-006 SHALL have ports year_thou, year_hund, year_ten, year_unit, input, 4 each, BCD year digits.
REQ-007 SHALL have ports month_ten, day_ten, hour_ten, input, 2 each; month_unit, day_unit, hour_unit, input, 4 each; BCD digits.
REQ-008 SHALL have ports min_ten, min_unit, sec_ten, sec_unit, input, 4 each, BCD digits.
REQ-009 SHALL have port tx, output, 1, UART 8N1 line (idle high).
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at frame end.

Function
REQ-012 Frame: 21 ASCII chars "YYYY-MM-DD hh:mm:ss" then CR (0x0D) and LF (0x0A), sent in that order.
REQ-013 Digit char = 0x30 + zero-extended digit; any digit value > 9 is sent as '?' (0x3F).
REQ-014 Separators are fixed: '-' 0x2D, ' ' 0x20, ':' 0x3A.
REQ-015 Each char: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 No idle gap between chars. The next start bit directly follows the previous stop bit.
REQ-017 start is sampled on each rising clk edge. It is accepted only when busy=0 and done=0.
REQ-018 On acceptance, all 14 digit inputs are latched in that same edge. Input changes afterwards do not affect the frame in flight.
REQ-019 After acceptance, busy=1 and tx=0 (start bit of char 0) are registered on the accepting edge, so latency from start to the first start bit is 1 cycle.
REQ-020 start while busy=1, or in the done cycle, SHALL be ignored. No queuing.
REQ-021 Total frame length from the first start-bit cycle to the last stop-bit cycle is 21 × 10 × CLKS_PER_BIT cycles.
REQ-022 On the cycle after the last stop bit completes:
- done=1 for exactly one cycle;
- busy=0 in that same cycle;
- tx=1.
REQ-023 FSM states and transitions:
- IDLE -> START on an accepted start.
- START -> DATA after 1 bit time.
- DATA -> STOP after 8 bit times.
- STOP -> START if char index < 20, with the index incremented.
- STOP -> DONE if char index = 20.
- DONE -> IDLE after 1 cycle.
REQ-024 The bit-time counter reloads at every bit boundary. The char index is 5 bits (0–20) and never wraps within a frame.
REQ-025 tx SHALL be driven from a register, so it is glitch-free.

Reset
REQ-026 While rst_n=0: tx=1, busy=0, done=0, FSM=IDLE, all counters=0, latched digits=0.
REQ-027 Assertion of rst_n mid-frame SHALL abort the frame immediately (asynchronously), with tx forced to 1.
REQ-028 After reset release, the block accepts start on the first clk edge.

Structure
REQ-029 A shared package SHALL hold:
- ASCII constants (0x30, 0x2D, 0x20, 0x3A, 0x0D, 0x0A, 0x3F);
- FRAME_LEN = 21;
- the FSM state enumeration.
REQ-030 Baud timing SHALL live in one sub-module, baud_tick_gen. It is parameterized by CLKS_PER_BIT, has a synchronous restart input and an async reset, and emits a bit-end tick.
REQ-031 Char selection SHALL be combinational, from the char index and the latched digits. The serializer is a 10-bit shift register.

Verification (bench uses F_IN=16, BAUD=1, so CLKS_PER_BIT=16)
REQ-032 Basic frame:
- Stimulus: digits 2025-03-07 14:09:58, start pulsed for 1 cycle.
- Required: the line decodes to 32 30 32 35 2D 30 33 2D 30 37 20 31 34 3A 30 39 3A 35 38 0D 0A.
- Required: tx falls 1 cycle after the accepting edge.
- Required: done occurs exactly 3360 cycles after the first start bit; busy is high throughout.
REQ-033 Input stability:
- Stimulus: change all digit inputs to 9 every cycle after acceptance.
- Required: the transmitted frame equals the snapshot values.
REQ-034 Start handling:
- Stimulus: start held high continuously.
- Required: frames repeat, separated by exactly one done cycle plus one IDLE acceptance edge, and no frame is truncated.
- Stimulus: start pulsed mid-frame.
- Required: the pulse is ignored.
REQ-035 Invalid digit:
- Stimulus: sec_unit = 4'hC.
- Required: char 18 is 0x3F; all other chars are unchanged.
REQ-036 Reset mid-frame:
- Stimulus: rst_n low during char 5, data bit 3.
- Required: tx=1, busy=0, done=0 immediately.
- Stimulus: after release, start pulsed.
- Required: a complete, correct frame from char 0.
REQ-037 Boundary:
- Stimulus: digits 9999-12-31 23:59:59.
- Required: the correct 21-char frame; the bit-period counter is measured at 16 cycles per bit for all 210 bits.
